// File: rtl/transition_window_accum_pkg.sv
// rtl/transition_window_accum_pkg.sv - shared types and width helpers for the transition window accumulator
package qtt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ACCUM = 2'd2
  } state_e;

  // Accumulator width: one per-word count field plus enough bits for the window length.
  function automatic int sum_width(input int word_size, input int win_w);
    return $clog2(word_size) + win_w;
  endfunction

endpackage

// File: rtl/transition_window_accum_if.sv
// rtl/transition_window_accum_if.sv - control, count stream and result bundle; out_min/out_max under QTT_WINDOW_MINMAX_EN
interface transition_window_accum_if #(
  parameter int WORD_SIZE = 64,
  parameter int WIN_W     = 16
) ();
  import qtt_pkg::*;

  localparam int CNT_W = $clog2(WORD_SIZE);
  localparam int SUM_W = sum_width(WORD_SIZE, WIN_W);

  logic             enable;
  logic [WIN_W-1:0] win_len;
  logic [SUM_W-1:0] threshold;
  logic             in_valid;
  logic [CNT_W-1:0] in_count;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic             out_over;
  logic             drop;
  logic             busy;
`ifdef QTT_WINDOW_MINMAX_EN
  logic [CNT_W-1:0] out_min;
  logic [CNT_W-1:0] out_max;
`endif

  modport master (
    output enable, win_len, threshold, in_valid, in_count, out_ready,
    input  out_valid, out_sum, out_over, drop, busy
`ifdef QTT_WINDOW_MINMAX_EN
    , input out_min, out_max
`endif
  );

  modport slave (
    input  enable, win_len, threshold, in_valid, in_count, out_ready,
    output out_valid, out_sum, out_over, drop, busy
`ifdef QTT_WINDOW_MINMAX_EN
    , output out_min, out_max
`endif
  );

endinterface

// File: rtl/transition_window_accum_minmax.sv
// rtl/transition_window_accum_minmax.sv - per-window min/max of in_count, used under QTT_WINDOW_MINMAX_EN
module tw_minmax #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             accept_i,
  input  logic             complete_i,
  input  logic             take_i,
  input  logic [CNT_W-1:0] count_i,
  output logic [CNT_W-1:0] out_min_o,
  output logic [CNT_W-1:0] out_max_o
);

  logic [CNT_W-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
  logic [CNT_W-1:0] min_q, min_d, max_q, max_d;
  logic [CNT_W-1:0] word_min, word_max;

  assign word_min = (count_i < run_min_q) ? count_i : run_min_q;
  assign word_max = (count_i > run_max_q) ? count_i : run_max_q;

  // Running extremes restart at each window; reported pair follows the sum register.
  always_comb begin
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    min_d     = min_q;
    max_d     = max_q;
    if (clr_i) begin
      run_min_d = '1;
      run_max_d = '0;
    end
    if (accept_i) begin
      if (complete_i) begin
        run_min_d = '1;
        run_max_d = '0;
        if (take_i) begin
          min_d = word_min;
          max_d = word_max;
        end
      end else begin
        run_min_d = word_min;
        run_max_d = word_max;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_min_q <= '1;
      run_max_q <= '0;
      min_q     <= '1;
      max_q     <= '0;
    end else begin
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      min_q     <= min_d;
      max_q     <= max_d;
    end
  end

  assign out_min_o = min_q;
  assign out_max_o = max_q;

endmodule

// File: rtl/transition_window_accum.sv
// rtl/transition_window_accum.sv - windowed sign-change sum with threshold flag; QTT_WINDOW_MINMAX_EN adds min/max
module transition_window_accum
  import qtt_pkg::*;
#(
  parameter int WORD_SIZE = 64,
  parameter int WIN_W     = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  transition_window_accum_if.slave bus
);

  localparam int CNT_W = $clog2(WORD_SIZE);
  localparam int SUM_W = sum_width(WORD_SIZE, WIN_W);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d, rem_q, rem_d;
  logic [SUM_W-1:0] thr_q, thr_d, acc_q, acc_d, sum_q, sum_d;
  logic             valid_q, valid_d, over_q, over_d, drop_q, drop_d;
  logic             busy;

  logic [WIN_W-1:0] win_eff;
  logic [SUM_W-1:0] acc_sum;
  logic             accept, last_word, complete, take;

  assign win_eff   = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
  assign acc_sum   = acc_q + SUM_W'(bus.in_count);
  assign accept    = (state_q == ACCUM) && bus.in_valid;
  assign last_word = (rem_q == WIN_W'(1));
  assign complete  = accept && last_word;
  // A finished window is only taken if the output slot is free or being emptied now.
  assign take      = complete && (!valid_q || bus.out_ready);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: enable low returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.enable) state_d = LOAD;
      LOAD:    state_d = bus.enable ? ACCUM : IDLE;
      ACCUM:   if (!bus.enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Datapath next state: window setup, accumulation, result slot and drop flag.
  always_comb begin
    win_d   = win_q;
    rem_d   = rem_q;
    thr_d   = thr_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    over_d  = over_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    if (state_q == IDLE && bus.enable) drop_d = 1'b0;
    if (state_q == LOAD) begin
      win_d = win_eff;
      rem_d = win_eff;
      thr_d = bus.threshold;
      acc_d = '0;
    end
    if (valid_q && bus.out_ready) valid_d = 1'b0;
    if (accept) begin
      if (last_word) begin
        acc_d = '0;
        rem_d = win_q;
        if (take) begin
          sum_d   = acc_sum;
          over_d  = (acc_sum > thr_q);
          valid_d = 1'b1;
        end else begin
          drop_d = 1'b1;
        end
      end else begin
        acc_d = acc_sum;
        rem_d = rem_q - WIN_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q   <= '0;
      rem_q   <= '0;
      thr_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      over_q  <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      win_q   <= win_d;
      rem_q   <= rem_d;
      thr_q   <= thr_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      over_q  <= over_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_over  = over_q;
  assign bus.drop      = drop_q;
  assign bus.busy      = busy;

`ifdef QTT_WINDOW_MINMAX_EN
  tw_minmax #(.CNT_W(CNT_W)) u_minmax (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (state_q == LOAD),
    .accept_i   (accept),
    .complete_i (complete),
    .take_i     (take),
    .count_i    (bus.in_count),
    .out_min_o  (bus.out_min),
    .out_max_o  (bus.out_max)
  );
`endif

endmodule

// File: tb/tb_transition_window_accum.sv
// tb/tb_transition_window_accum.sv - directed and random checks of transition_window_accum against a window-list model
module tb_transition_window_accum;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  transition_window_accum_if #(.WORD_SIZE(64), .WIN_W(16)) bus ();

  transition_window_accum #(.WORD_SIZE(64), .WIN_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 load, 2 accumulate; words of the open window kept as a list.
  int          m_mode, m_len, m_th;
  int unsigned words[$];
  bit          m_valid, m_over, m_drop;
  int          m_sum, m_min, m_max;

  task automatic model_reset();
    m_mode = 0; m_len = 0; m_th = 0;
    words.delete();
    m_valid = 0; m_over = 0; m_drop = 0;
    m_sum = 0; m_min = 63; m_max = 0;
  endtask

  task automatic model_edge();
    bit vb;
    bit loaded;
    int s, mn, mx;
    vb = m_valid;
    loaded = 0;
    case (m_mode)
      0: if (bus.enable) begin m_mode = 1; m_drop = 0; end
      1: begin
        m_len = (bus.win_len == 0) ? 1 : int'(bus.win_len);
        m_th  = int'(bus.threshold);
        words.delete();
        m_mode = bus.enable ? 2 : 0;
      end
      default: begin
        if (bus.in_valid) begin
          words.push_back(bus.in_count);
          if (words.size() == m_len) begin
            s = 0; mn = 63; mx = 0;
            foreach (words[k]) begin
              s += words[k];
              if (words[k] < mn) mn = words[k];
              if (words[k] > mx) mx = words[k];
            end
            if (!vb || bus.out_ready) begin
              m_valid = 1; m_sum = s; m_over = (s > m_th);
              m_min = mn; m_max = mx; loaded = 1;
            end else begin
              m_drop = 1;
            end
            words.delete();
          end
        end
        if (!bus.enable) m_mode = 0;
      end
    endcase
    if (vb && bus.out_ready && !loaded) m_valid = 0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("busy", 64'(bus.busy), 64'(m_mode != 0));
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    check("drop", 64'(bus.drop), 64'(m_drop));
    if (m_valid) begin
      check("out_sum", 64'(bus.out_sum), 64'(m_sum));
      check("out_over", 64'(bus.out_over), 64'(m_over));
`ifdef QTT_WINDOW_MINMAX_EN
      check("out_min", 64'(bus.out_min), 64'(m_min));
      check("out_max", 64'(bus.out_max), 64'(m_max));
`endif
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", 64'(bus.out_sum), 64'd0);
    check("rst_over", 64'(bus.out_over), 64'd0);
    check("rst_drop", 64'(bus.drop), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
`ifdef QTT_WINDOW_MINMAX_EN
    check("rst_min", 64'(bus.out_min), 64'd63);
    check("rst_max", 64'(bus.out_max), 64'd0);
`endif
    @(posedge clk);
    #1;
    check_all();
    #3;
    rst_n = 1'b1;
  endtask

  task automatic start(input int wl, input int th);
    bus.enable = 1'b1; bus.win_len = 16'(wl); bus.threshold = 22'(th); bus.in_valid = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic stop();
    bus.enable = 1'b0; bus.in_valid = 1'b0;
    cycle();
  endtask

  task automatic feed(input int c);
    bus.in_valid = 1'b1; bus.in_count = 6'(c);
    cycle();
  endtask

  initial begin
    nvec = 0; nerr = 0;
    rst_n = 1'b1;
    bus.enable = 1'b0; bus.win_len = '0; bus.threshold = '0;
    bus.in_valid = 1'b0; bus.in_count = '0; bus.out_ready = 1'b0;
    model_reset();
    #2;
    do_reset();

    // 4-word window, threshold just below and at the sum
    bus.out_ready = 1'b1;
    start(4, 70);
    feed(3); feed(5); feed(0); feed(63);
    check("w4_sum", 64'(bus.out_sum), 64'd71);
    check("w4_over_th70", 64'(bus.out_over), 64'd1);
    stop();
    start(4, 71);
    feed(3); feed(5); feed(0); feed(63);
    check("w4_over_th71", 64'(bus.out_over), 64'd0);

    // win_len 0 behaves as 1: results on consecutive cycles
    stop();
    start(0, 100);
    feed(7);
    check("wl0_first", 64'(bus.out_sum), 64'd7);
    feed(9);
    check("wl0_second", 64'(bus.out_sum), 64'd9);
    check("wl0_valid", 64'(bus.out_valid), 64'd1);
    stop();

    // back-pressure across three windows
    bus.out_ready = 1'b0;
    start(2, 0);
    feed(1); feed(2);
    feed(4); feed(4);
    feed(5); feed(5);
    check("bp_held_sum", 64'(bus.out_sum), 64'd3);
    check("bp_drop", 64'(bus.drop), 64'd1);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    cycle();
    check("bp_accepted", 64'(bus.out_valid), 64'd0);
    stop();

    // abort a partial window, then a clean window clears drop
    start(4, 0);
    feed(1); feed(1);
    stop();
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    start(4, 0);
    feed(1); feed(1); feed(1); feed(1);
    check("restart_sum", 64'(bus.out_sum), 64'd4);
    check("restart_drop", 64'(bus.drop), 64'd0);
    stop();

    // asynchronous reset mid-window with a pending result
    bus.out_ready = 1'b0;
    start(2, 0);
    feed(9); feed(9);
    feed(1);
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    bus.in_valid = 1'b0; bus.enable = 1'b0;
    #2;
    do_reset();
    bus.out_ready = 1'b1;

`ifdef QTT_WINDOW_MINMAX_EN
    start(3, 0);
    feed(10); feed(2); feed(40);
    check("mm_min", 64'(bus.out_min), 64'd2);
    check("mm_max", 64'(bus.out_max), 64'd40);
    check("mm_sum", 64'(bus.out_sum), 64'd52);
    stop();
`endif

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      bus.enable    = ($urandom_range(0, 39) != 0);
      bus.win_len   = 16'($urandom_range(0, 5));
      bus.threshold = 22'($urandom_range(0, 200));
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_count  = 6'($urandom_range(0, 63));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/transition_window_accum.md
TRANSITION_WINDOW_ACCUM -- requirements
Module: transition_window_accum

Interface
REQ-001 Parameter WORD_SIZE, default 64, SHALL set the width of the upstream data word; CNT_W = $clog2(WORD_SIZE).
REQ-002 Parameter WIN_W, default 16, SHALL set the width of the window-length input; SUM_W = CNT_W + WIN_W.
REQ-003 clk  input  1  SHALL be the single clock; all state on rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-005 enable  input  1  SHALL be the level run enable.
REQ-006 win_len  input  WIN_W  SHALL be words per window, sampled in LOAD; 0 is treated as 1.
REQ-007 threshold  input  SUM_W  SHALL be the compare level, sampled in LOAD.
REQ-008 in_valid  input  1  SHALL qualify in_count; there is no in_ready (upstream does not stall).
REQ-009 in_count  input  CNT_W  SHALL be the per-word sign-change count from upstream.
REQ-010 out_valid  output  1, out_ready  input  1  SHALL form the result handshake.
REQ-011 out_sum  output  SUM_W  SHALL be the completed window sum.
REQ-012 out_over  output  1  SHALL be 1 when out_sum > latched threshold.
REQ-013 drop  output  1  SHALL be a sticky flag: a completed window was lost.
REQ-014 busy  output  1  SHALL be 1 whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, ACCUM.
REQ-016 IDLE->LOAD when enable=1; LOAD->ACCUM unconditionally after one cycle; any state->IDLE on the cycle after enable=0.
REQ-017 LOAD SHALL latch win_len (0 becomes 1) and threshold, clear the accumulator, and load the remaining-word counter.
REQ-018 in_valid SHALL be ignored in IDLE and LOAD.
REQ-019 In ACCUM, each in_valid SHALL add in_count (zero-extended) to the accumulator and decrement the remaining counter.
REQ-020 On the in_valid that takes remaining from 1 to 0, the final sum (including that word) SHALL be offered to the output register, and the accumulator and counter SHALL reload in the same cycle. Windows run back to back with no idle cycle.
REQ-021 Latency: out_valid SHALL rise on the cycle after the window's last accepted word.
REQ-022 out_sum and out_over SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 If a window completes while out_valid=1 and out_ready=0, the new result SHALL be discarded, the held result kept, and drop set.
REQ-024 If a window completes while out_valid=1 and out_ready=1, the new result SHALL load and out_valid SHALL stay 1.
REQ-025 On enable=0, the partial window SHALL be discarded; a pending out_valid result SHALL still complete its handshake.
REQ-026 The accumulator SHALL not overflow by construction: SUM_W bits hold (WORD_SIZE-1)*(2^WIN_W-1).
REQ-027 drop SHALL clear only on reset or on the IDLE->LOAD transition.

Reset
REQ-028 rst_n=0 SHALL asynchronously force:
- state = IDLE
- out_valid, out_over, drop, busy = 0
- out_sum, accumulator, counter = 0
REQ-029 Reset deassertion mid-window SHALL restart from IDLE with no residual result.

Configuration
REQ-030 Macro QTT_WINDOW_MINMAX_EN defined SHALL add two outputs, out_min and out_max (each CNT_W), holding the minimum and maximum in_count of the reported window. They update and stall together with out_sum.
REQ-031 Reset value of out_min SHALL be all-ones; reset value of out_max SHALL be 0.
REQ-032 Without the macro, those ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 The state enum (IDLE/LOAD/ACCUM) and a sum-width helper function SHALL live in the shared package qtt_pkg.
REQ-034 Min/max tracking SHALL be a sub-module, tw_minmax, instantiated only under QTT_WINDOW_MINMAX_EN.

Verification
REQ-035 win_len=4, counts 3,5,0,63 on consecutive cycles, out_ready=1 -> out_sum=71 one cycle after the 4th word; out_over=1 for threshold=70, 0 for threshold=71.
REQ-036 win_len=0, counts 7,9 -> two results, 7 then 9, on consecutive cycles.
REQ-037 win_len=2, out_ready=0 across three windows -> first sum held stable and drop=1; then out_ready=1 -> first sum accepted.
REQ-038 enable dropped after 2 of 4 words -> busy=0 next cycle, no result; re-enable, 4 words of 1 -> out_sum=4, drop=0.
REQ-039 rst_n pulsed low asynchronously mid-window with out_valid=1 -> all outputs immediately at reset values.
REQ-040 With QTT_WINDOW_MINMAX_EN, counts 10,2,40 (win_len=3) -> out_min=2, out_max=40, out_sum=52.
